// File: rtl/debounce_pkg.sv
// Shared defaults and helpers for the keypad debouncer.
package debounce_pkg;

  localparam int unsigned DB_DEFAULT_TICKS = 8;
  localparam int unsigned DB_DEFAULT_SYNC  = 2;

  // Counter only needs to reach ticks-1, so $clog2(ticks) bits suffice.
  function automatic int unsigned db_cnt_w(input int unsigned ticks);
    return (ticks < 2) ? 1 : $clog2(ticks);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer lane: synchroniser, stability counter, accepted level and edge pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DB_DEFAULT_TICKS,
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter int unsigned SYNC_STAGES  = DB_DEFAULT_SYNC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_en,
  input  logic raw,
  output logic db,
  output logic press_p,
  output logic release_p
);

  localparam int unsigned     CntW    = db_cnt_w(STABLE_TICKS);
  localparam logic [CntW-1:0] CntMax  = CntW'(STABLE_TICKS - 1);
  // Raw pin level when the key is not pressed.
  localparam logic            IdleLvl = ACTIVE_LOW;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   lvl;

  // Synchroniser runs every clk; reset to idle so deassertion cannot fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{IdleLvl}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign lvl = ACTIVE_LOW ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];

  // Any sample matching the accepted level restarts qualification from zero.
  always_comb begin
    cnt_d     = cnt_q;
    db_d      = db_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (tick_en) begin
      if (lvl == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntMax) begin
        db_d      = lvl;
        cnt_d     = '0;
        press_d   = lvl;
        release_d = ~lvl;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Accepted level, counter and one-clk pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      db_q      <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign db        = db_q;
  assign press_p   = press_q;
  assign release_p = release_q;

endmodule

// File: rtl/module_debounce_vec.sv
// N-channel keypad row debouncer with aggregate press strobe and any-pressed level.
module module_debounce_vec
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned STABLE_TICKS = DB_DEFAULT_TICKS,
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter int unsigned SYNC_STAGES  = DB_DEFAULT_SYNC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick_en,
  input  logic [N_CH-1:0] filas_in,
  output logic [N_CH-1:0] filas_db,
  output logic [N_CH-1:0] press_p,
  output logic [N_CH-1:0] release_p,
  output logic            enable,
  output logic            any_pressed
);

  for (genvar i = 0; i < N_CH; i++) begin : gen_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_channel (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_en   (tick_en),
      .raw       (filas_in[i]),
      .db        (filas_db[i]),
      .press_p   (press_p[i]),
      .release_p (release_p[i])
    );
  end

  // Aggregates are plain ORs of registered outputs, so they add no latency.
  assign enable      = |press_p;
  assign any_pressed = |filas_db;

endmodule
